// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
// Instruction fetch stage of the Gumnut core. Owns the 12-bit program counter
// and a return-address stack. It runs one Wishbone-classic read per fetch
// request and hands the fetched word to the instruction register with a
// single-cycle write strobe. The core control FSM commands next-PC selection
// while the stage is idle.
//
// Optional feature macro: INST_FETCH_RAS_CHECK_EN
//   defined   : stack overflow/underflow are detected and reported on the
//               sticky stack_err_o flag.
//   undefined : the stack pointer wraps silently and stack_err_o is tied low.
//
// Ports
//   clk, rst          core clock, synchronous active-high reset
//   cen               clock enable; all state holds while low
//   fetch_req_i       start one fetch at the current PC (honoured in IDLE)
//   pc_upd_i          apply the next-PC selection (honoured in IDLE)
//   pc_sel_i          0 seq/no-op, 1 jump, 2 branch, 3 jsb, 4 ret, 5-7 no-op
//   addr_i            absolute target for jump and jsb
//   disp_i            signed branch displacement
//   inst_cyc_o/stb_o  Wishbone cycle and strobe
//   inst_adr_o        fetch address, stable throughout the bus cycle
//   inst_dat_i        fetched word
//   inst_ack_i        Wishbone acknowledge
//   inst_o            word for the instruction register
//   ir_we_o           instruction register write strobe
//   fetch_busy_o      high while a fetch is in progress
//   pc_o              current PC
//   stack_err_o       sticky stack fault
// -----------------------------------------------------------------------------
module inst_fetch #(
    parameter int RAS_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        fetch_req_i,
    input  logic        pc_upd_i,
    input  logic [2:0]  pc_sel_i,
    input  logic [11:0] addr_i,
    input  logic [7:0]  disp_i,
    output logic        inst_cyc_o,
    output logic        inst_stb_o,
    output logic [11:0] inst_adr_o,
    input  logic [17:0] inst_dat_i,
    input  logic        inst_ack_i,
    output logic [17:0] inst_o,
    output logic        ir_we_o,
    output logic        fetch_busy_o,
    output logic [11:0] pc_o,
    output logic        stack_err_o
);
    localparam int              SP_W   = $clog2(RAS_DEPTH);
    localparam logic [SP_W-1:0] SP_ONE = SP_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [11:0]       pc_r;
    logic [11:0]       pc_nxt_s;
    logic [SP_W-1:0]   sp_r;
    logic [SP_W-1:0]   sp_nxt_s;
    logic [SP_W-1:0]   sp_dec_s;
    logic              ras_we_s;
    logic [11:0]       ras_r [RAS_DEPTH];
    logic [17:0]       inst_r;
    logic              bus_r;
    logic [11:0]       adr_r;
    logic              ir_we_r;
    logic              busy_r;

`ifdef INST_FETCH_RAS_CHECK_EN
    localparam logic [SP_W:0] CNT_FULL = (SP_W+1)'(RAS_DEPTH);
    localparam logic [SP_W:0] CNT_ONE  = (SP_W+1)'(1);
    logic [SP_W:0]     cnt_r;
    logic [SP_W:0]     cnt_nxt_s;
    logic              err_r;
    logic              err_nxt_s;
`endif

    // Pop reads the entry just below the pointer.
    assign sp_dec_s = sp_r - SP_ONE;

    // Next-state, next-PC and stack control.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        sp_nxt_s    = sp_r;
        ras_we_s    = 1'b0;
`ifdef INST_FETCH_RAS_CHECK_EN
        cnt_nxt_s   = cnt_r;
        err_nxt_s   = err_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (pc_upd_i) begin
                    case (pc_sel_i)
                        3'd1: pc_nxt_s = addr_i;
                        // PC is already post-incremented, so the branch is
                        // relative to the following instruction.
                        3'd2: pc_nxt_s = pc_r + {{4{disp_i[7]}}, disp_i};
                        3'd3: begin
`ifdef INST_FETCH_RAS_CHECK_EN
                            if (cnt_r == CNT_FULL) begin
                                err_nxt_s = 1'b1;
                            end else begin
                                ras_we_s  = 1'b1;
                                sp_nxt_s  = sp_r + SP_ONE;
                                cnt_nxt_s = cnt_r + CNT_ONE;
                            end
`else
                            ras_we_s = 1'b1;
                            sp_nxt_s = sp_r + SP_ONE;
`endif
                            pc_nxt_s = addr_i;
                        end
                        3'd4: begin
`ifdef INST_FETCH_RAS_CHECK_EN
                            if (cnt_r == {(SP_W+1){1'b0}}) begin
                                pc_nxt_s  = 12'd0;
                                err_nxt_s = 1'b1;
                            end else begin
                                pc_nxt_s  = ras_r[sp_dec_s];
                                sp_nxt_s  = sp_dec_s;
                                cnt_nxt_s = cnt_r - CNT_ONE;
                            end
`else
                            pc_nxt_s = ras_r[sp_dec_s];
                            sp_nxt_s = sp_dec_s;
`endif
                        end
                        default: pc_nxt_s = pc_r;
                    endcase
                end else begin
                    pc_nxt_s = pc_r;
                end
                if (fetch_req_i) begin
                    state_nxt_s = ST_BUS;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUS: begin
                if (inst_ack_i) begin
                    state_nxt_s = ST_LOAD;
                    pc_nxt_s    = pc_r + 12'd1;
                end else begin
                    state_nxt_s = ST_BUS;
                end
            end
            ST_LOAD: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, PC and registered bus/IR outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            pc_r    <= 12'd0;
            sp_r    <= {SP_W{1'b0}};
            inst_r  <= 18'd0;
            bus_r   <= 1'b0;
            adr_r   <= 12'd0;
            ir_we_r <= 1'b0;
            busy_r  <= 1'b0;
        end else if (cen) begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            sp_r    <= sp_nxt_s;
            if (state_r == ST_BUS && inst_ack_i) begin
                inst_r <= inst_dat_i;
            end
            bus_r   <= (state_nxt_s == ST_BUS);
            ir_we_r <= (state_nxt_s == ST_LOAD);
            busy_r  <= (state_nxt_s != ST_IDLE);
            // Address is captured on entry to BUS, after any same-cycle update.
            if (state_r == ST_IDLE && state_nxt_s == ST_BUS) begin
                adr_r <= pc_nxt_s;
            end
        end
    end

    // Return-address storage; contents are not reset.
    always_ff @(posedge clk) begin
        if (!rst && cen && ras_we_s) begin
            ras_r[sp_r] <= pc_r;
        end
    end

`ifdef INST_FETCH_RAS_CHECK_EN
    // Occupancy count and sticky fault flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {(SP_W+1){1'b0}};
            err_r <= 1'b0;
        end else if (cen) begin
            cnt_r <= cnt_nxt_s;
            err_r <= err_nxt_s;
        end
    end

    assign stack_err_o = err_r;
`else
    assign stack_err_o = 1'b0;
`endif

    assign inst_cyc_o   = bus_r;
    assign inst_stb_o   = bus_r;
    assign inst_adr_o   = adr_r;
    assign inst_o       = inst_r;
    assign ir_we_o      = ir_we_r;
    assign fetch_busy_o = busy_r;
    assign pc_o         = pc_r;

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
// Self-checking bench for inst_fetch. A transaction-level model (PC value plus
// a return stack kept as a queue or a circular array) predicts the PC and the
// word each fetch must deliver; expectations go into a scoreboard queue that a
// monitor drains whenever the instruction register is written.
// -----------------------------------------------------------------------------
module tb_inst_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen;
    logic        fetch_req_i = 1'b0;
    logic        pc_upd_i = 1'b0;
    logic [2:0]  pc_sel_i = 3'd0;
    logic [11:0] addr_i = 12'd0;
    logic [7:0]  disp_i = 8'd0;
    logic        inst_cyc_o, inst_stb_o;
    logic [11:0] inst_adr_o;
    logic [17:0] inst_dat_i;
    logic        inst_ack_i;
    logic [17:0] inst_o;
    logic        ir_we_o, fetch_busy_o, stack_err_o;
    logic [11:0] pc_o;

    inst_fetch #(.RAS_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .cen(cen),
        .fetch_req_i(fetch_req_i), .pc_upd_i(pc_upd_i), .pc_sel_i(pc_sel_i),
        .addr_i(addr_i), .disp_i(disp_i),
        .inst_cyc_o(inst_cyc_o), .inst_stb_o(inst_stb_o), .inst_adr_o(inst_adr_o),
        .inst_dat_i(inst_dat_i), .inst_ack_i(inst_ack_i),
        .inst_o(inst_o), .ir_we_o(ir_we_o), .fetch_busy_o(fetch_busy_o),
        .pc_o(pc_o), .stack_err_o(stack_err_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- memory and bus slave ----------------
    logic [17:0] mem [4096];
    int  ws_force = -1;
    bit  slave_en = 1'b1;
    bit  late_ack = 1'b0;
    int  wcnt, cur_ws;

    initial begin
        inst_ack_i = 1'b0;
        inst_dat_i = 18'd0;
        wcnt = 0;
        cur_ws = 0;
        forever begin
            @(negedge clk);
            if (!slave_en) begin
                inst_ack_i = late_ack;
                inst_dat_i = 18'h3FFFF;
            end else if (!inst_stb_o) begin
                inst_ack_i = 1'b0;
                wcnt = 0;
                cur_ws = (ws_force >= 0) ? ws_force : int'($urandom_range(0, 3));
            end else if (!inst_ack_i) begin
                if (wcnt >= cur_ws) begin
                    inst_ack_i = 1'b1;
                    inst_dat_i = mem[inst_adr_o];
                end else begin
                    wcnt++;
                end
            end
        end
    end

    // ---------------- clock enable ----------------
    bit cen_rand = 1'b0;
    initial begin
        cen = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cen = cen_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // ---------------- reference model ----------------
    logic [11:0] m_pc;
    bit          m_err;
`ifdef INST_FETCH_RAS_CHECK_EN
    logic [11:0] m_q [$];
`else
    logic [11:0] m_stk [8];
    bit          m_valid [8];
    int          m_sp;
`endif

    task automatic model_reset();
        m_pc  = 12'd0;
        m_err = 1'b0;
`ifdef INST_FETCH_RAS_CHECK_EN
        m_q.delete();
`else
        m_sp = 0;
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
`endif
    endtask

    task automatic model_upd(logic [2:0] sel, logic [11:0] a, logic [7:0] d);
        case (sel)
            3'd1: m_pc = a;
            3'd2: m_pc = m_pc + {{4{d[7]}}, d};
            3'd3: begin
`ifdef INST_FETCH_RAS_CHECK_EN
                if (m_q.size() == 8) m_err = 1'b1;
                else m_q.push_back(m_pc);
`else
                m_stk[m_sp] = m_pc;
                m_valid[m_sp] = 1'b1;
                m_sp = (m_sp + 1) % 8;
`endif
                m_pc = a;
            end
            3'd4: begin
`ifdef INST_FETCH_RAS_CHECK_EN
                if (m_q.size() == 0) begin
                    m_pc = 12'd0;
                    m_err = 1'b1;
                end else begin
                    m_pc = m_q.pop_back();
                end
`else
                m_sp = (m_sp + 7) % 8;
                m_pc = m_stk[m_sp];
`endif
            end
            default: ;
        endcase
    endtask

    // ---------------- scoreboard monitor ----------------
    typedef struct packed {
        logic [17:0] inst;
        logic [11:0] pc;
    } exp_t;
    exp_t sb_q [$];

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ir_we_o && cen && !rst) begin
                if (sb_q.size() == 0) begin
                    chk("ir_we_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("ir_inst", inst_o, e.inst);
                    chk("ir_pc", pc_o, e.pc);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_fetch();
        exp_t e;
        e.inst = mem[m_pc];
        e.pc   = m_pc + 12'd1;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic drive(bit upd, logic [2:0] sel, logic [11:0] a, logic [7:0] d, bit f);
        int guard = 0;
        @(negedge clk);
        pc_upd_i = upd; pc_sel_i = sel; addr_i = a; disp_i = d; fetch_req_i = f;
        while (!cen && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) chk("cen_timeout", 32'd1, 32'd0);
        @(negedge clk);
        pc_upd_i = 1'b0; fetch_req_i = 1'b0;
    endtask

    task automatic op(bit upd, logic [2:0] sel, logic [11:0] a, logic [7:0] d, bit f);
        int guard = 0;
        if (upd) model_upd(sel, a, d);
        if (f) push_fetch();
        drive(upd, sel, a, d, f);
        if (f) begin
            while (fetch_busy_o && guard < 300) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 300) chk("fetch_timeout", 32'd1, 32'd0);
            m_pc = m_pc + 12'd1;
        end
        chk("pc", pc_o, m_pc);
        chk("stack_err", stack_err_o, m_err);
    endtask

    // Fetch with fixed wait states and cycle-exact checks (cen held high).
    task automatic fetch_timed(int ws, bit jmp, logic [11:0] a);
        logic [11:0] exp_adr;
        ws_force = ws;
        if (jmp) model_upd(3'd1, a, 8'd0);
        exp_adr = m_pc;
        push_fetch();
        @(negedge clk);
        fetch_req_i = 1'b1; pc_upd_i = jmp; pc_sel_i = 3'd1; addr_i = a;
        for (int c = 1; c <= ws + 3; c++) begin
            @(negedge clk);
            fetch_req_i = 1'b0; pc_upd_i = 1'b0;
            chk("stb", inst_stb_o, (c <= ws + 1));
            chk("cyc", inst_cyc_o, (c <= ws + 1));
            chk("ir_we", ir_we_o, (c == ws + 2));
            if (c <= ws + 1) chk("adr", inst_adr_o, exp_adr);
        end
        chk("busy_end", fetch_busy_o, 32'd0);
        m_pc = m_pc + 12'd1;
        chk("pc_timed", pc_o, m_pc);
        ws_force = -1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [2:0]  sel;
        bit          upd, f;
        for (int i = 0; i < 4096; i++) mem[i] = 18'($urandom);
        mem[0] = 18'h2A5F3;
        model_reset();
        do_reset();

        @(negedge clk);
        chk("rst_pc", pc_o, 32'd0);
        chk("rst_inst", inst_o, 32'd0);
        chk("rst_ir_we", ir_we_o, 32'd0);
        chk("rst_cyc", inst_cyc_o, 32'd0);
        chk("rst_stb", inst_stb_o, 32'd0);
        chk("rst_adr", inst_adr_o, 32'd0);
        chk("rst_busy", fetch_busy_o, 32'd0);
        chk("rst_err", stack_err_o, 32'd0);

        // zero-wait fetch of 18'h2A5F3
        fetch_timed(0, 1'b0, 12'd0);
        chk("first_pc", pc_o, 32'h001);
        chk("first_inst", inst_o, 32'h2A5F3);

        // three wait states from address 0
        do_reset();
        fetch_timed(3, 1'b0, 12'd0);

        // branches, including wrap-around
        op(1'b1, 3'd1, 12'h010, 8'h00, 1'b0);
        op(1'b1, 3'd2, 12'h000, 8'hF0, 1'b0);
        chk("branch_back", pc_o, 32'h000);
        op(1'b1, 3'd1, 12'hFFF, 8'h00, 1'b0);
        op(1'b1, 3'd2, 12'h000, 8'h02, 1'b0);
        chk("branch_wrap", pc_o, 32'h001);

        // call and return
        op(1'b1, 3'd1, 12'h045, 8'h00, 1'b0);
        op(1'b1, 3'd3, 12'h300, 8'h00, 1'b0);
        chk("jsb_pc", pc_o, 32'h300);
        op(1'b1, 3'd4, 12'h000, 8'h00, 1'b0);
        chk("ret_pc", pc_o, 32'h045);

        // nine nested calls then nine returns
        do_reset();
        for (int i = 0; i < 9; i++) op(1'b1, 3'd3, 12'h100 + 12'(i), 8'h00, 1'b0);
`ifdef INST_FETCH_RAS_CHECK_EN
        chk("overflow_err", stack_err_o, 32'd1);
`else
        chk("overflow_err", stack_err_o, 32'd0);
`endif
        for (int i = 0; i < 9; i++) op(1'b1, 3'd4, 12'h000, 8'h00, 1'b0);
`ifdef INST_FETCH_RAS_CHECK_EN
        chk("ninth_ret", pc_o, 32'h000);
`else
        chk("ninth_ret", pc_o, 32'h107);
`endif

        // jump together with fetch request
        fetch_timed(1, 1'b1, 12'h7AB);

        // reset in the middle of a bus cycle, then a stray ack
        op(1'b1, 3'd1, 12'h5A5, 8'h00, 1'b0);
        ws_force = 20;
        @(negedge clk);
        fetch_req_i = 1'b1;
        @(negedge clk);
        fetch_req_i = 1'b0;
        chk("rstbus_stb_pre", inst_stb_o, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstbus_cyc", inst_cyc_o, 32'd0);
        chk("rstbus_stb", inst_stb_o, 32'd0);
        chk("rstbus_pc", pc_o, 32'd0);
        slave_en = 1'b0;
        late_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("late_ack_we", ir_we_o, 32'd0);
            chk("late_ack_busy", fetch_busy_o, 32'd0);
            chk("late_ack_pc", pc_o, 32'd0);
        end
        late_ack = 1'b0;
        @(negedge clk);
        slave_en = 1'b1;
        ws_force = -1;
        sb_q.delete();
        model_reset();

        // randomized traffic with clock-enable gaps
        do_reset();
        cen_rand = 1'b1;
        for (int n = 0; n < 400; n++) begin
            upd = 1'($urandom_range(0, 1));
            sel = 3'($urandom_range(0, 7));
            f   = 1'($urandom_range(0, 1));
`ifndef INST_FETCH_RAS_CHECK_EN
            if (upd && sel == 3'd4 && !m_valid[(m_sp + 7) % 8]) sel = 3'd3;
`endif
            op(upd, sel, 12'($urandom), 8'($urandom), f);
        end
        cen_rand = 1'b0;
        repeat (4) @(negedge clk);
        chk("sb_empty", sb_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage for the Gumnut core, directly upstream of the instruction register. Owns the 12-bit program counter and an 8-entry return-address stack, runs a Wishbone-classic read cycle on the instruction memory port, and delivers each fetched 18-bit word to the instruction register with a one-cycle write strobe. Next-PC selection (sequential, jump, branch, subroutine call, return) is commanded by the core control FSM after decode.

## Interface
Parameters:
- RAS_DEPTH, 8, return-address stack entries; power of two.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- cen  in  1  core clock enable; when 0 all state holds
- fetch_req_i  in  1  start one instruction fetch at current PC
- pc_upd_i  in  1  apply next-PC selection this cycle
- pc_sel_i  in  3  0 seq/no-op, 1 jump, 2 branch, 3 jsb, 4 ret, 5–7 treated as 0
- addr_i  in  12  absolute target (jump, jsb)
- disp_i  in  8  signed branch displacement
- inst_cyc_o  out  1  bus cycle
- inst_stb_o  out  1  bus strobe
- inst_adr_o  out  12  fetch address
- inst_dat_i  in  18  fetched word
- inst_ack_i  in  1  bus acknowledge
- inst_o  out  18  word to instruction register
- ir_we_o  out  1  instruction register write strobe, one cycle
- fetch_busy_o  out  1  high in BUS or LOAD
- pc_o  out  12  current PC
- stack_err_o  out  1  sticky stack fault (macro only; tied 0 otherwise)

## Operation
- FSM states: IDLE, BUS, LOAD. Transitions are taken only on edges with cen=1.
- IDLE: if fetch_req_i is set, go to BUS.
- BUS: inst_cyc_o and inst_stb_o are 1, and inst_adr_o = pc. On inst_ack_i=1:
  - inst_o <= inst_dat_i
  - pc <= pc+1 (mod 4096)
  - go to LOAD
- LOAD: ir_we_o=1 for exactly this one cycle, then go to IDLE.
- pc_upd_i is honoured only in IDLE:
  - sel 1: pc <= addr_i.
  - sel 2: pc <= pc + sext(disp_i), mod 4096. The PC is already post-incremented, so the offset is relative to the next instruction.
  - sel 3: push pc, then pc <= addr_i.
  - sel 4: pc <= pop.
- pc_upd_i is ignored in BUS and LOAD.
- Update and fetch_req_i in the same IDLE cycle: the update is applied on that edge, and the BUS cycle that follows uses the updated PC.
- Stack: array of 12-bit entries, 3-bit pointer sp and occupancy count 0..RAS_DEPTH.
- Push: writes the entry at sp, then sp++.
- Pop: sp--, then reads the entry at sp.

## Timing
- Reset values:
  - pc=0, inst_o=0, ir_we_o=0, inst_cyc_o=0, inst_stb_o=0, inst_adr_o=0, fetch_busy_o=0, pc_o=0
  - sp=0, count=0, stack_err_o=0, state IDLE
- Zero-wait fetch: fetch_req_i sampled at edge 0, stb high in cycle 1, ack sampled at edge 1, ir_we_o high in cycle 2, IR loads at edge 2.
- Each wait state on ack adds one cycle of latency.
- inst_adr_o is registered from pc and is stable for the whole BUS state.
- The slave holds ack and data until stb drops. An ack sampled while cen=0 has no effect.
- rst during BUS: cyc/stb are 0 from the next cycle. Any late ack arriving in IDLE is ignored.
- fetch_req_i in BUS or LOAD is ignored. It is not queued.

## Configuration
- INST_FETCH_RAS_CHECK_EN defined:
  - Push with count=RAS_DEPTH: no write, no sp change, the jump still taken, stack_err_o <= 1.
  - Pop with count=0: pc <= 0, sp unchanged, stack_err_o <= 1.
  - stack_err_o is sticky until rst.
- Undefined:
  - sp wraps modulo RAS_DEPTH. A push on full overwrites the oldest entry. A pop on empty returns whatever entry sp-1 holds.
  - stack_err_o is tied 0 and count logic is omitted.

## Test plan
- Reset, then fetch_req with ack in stb's first cycle and dat=18'h2A5F3: stb high in cycle 1, then ir_we_o=1 and inst_o=18'h2A5F3 in cycle 2, then pc_o=1.
- Ack delayed 3 cycles: stb held 4 cycles with adr constant 0, ir_we_o exactly one cycle, then the FSM returns to IDLE.
- pc=12'h010 with branch disp=8'hF0: pc=12'h000. Branch at pc=12'hFFF with disp=8'h02: wraps to 12'h001.
- jsb addr=12'h300 at pc=12'h045, then ret: pc=12'h300, then 12'h045. Nine nested jsb then nine ret:
  - with macro, stack_err_o=1 after the 9th push and the final ret gives pc=0;
  - without macro, the 9th ret returns the 9th pushed address.
- pc_upd jump to 12'h7AB together with fetch_req: the next BUS has inst_adr_o=12'h7AB. rst asserted in BUS: cyc/stb are 0 next cycle, pc=0, and a subsequent ack is ignored.
